// File: rtl/la_capture_pkg.sv
// Shared types and constants for the logic-analyzer capture sequencer.
package la_capture_pkg;
  localparam int LA_ADDR_W = 19;
  localparam int FLUSH_LEN = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ARMED,
    S_POST,
    S_FLUSH,
    S_DONE
  } cap_state_e;
endpackage

// File: rtl/la_wr_addr_cnt.sv
// SRAM write-address counter: synchronous clear, increment on write,
// one-cycle wrap pulse when incrementing from all-ones back to zero.
module la_wr_addr_cnt
  import la_capture_pkg::*;
#(
  parameter int ADDR_W = LA_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              wrap
);
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    wrap   = 1'b0;
    if (clr) begin
      addr_d = '0;
    end else if (inc) begin
      addr_d = addr_q + ADDR_W'(1);
      wrap   = &addr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) addr_q <= '0;
    else     addr_q <= addr_d;
  end

  assign addr = addr_q;
endmodule

// File: rtl/la_capture_ctrl.sv
// Capture sequencer: pre-trigger fill, armed ring buffer, post-trigger count,
// fixed RLE flush, and SRAM write strobe/address generation.
module la_capture_ctrl
  import la_capture_pkg::*;
#(
  parameter int ADDR_W = LA_ADDR_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic              STOP,
  input  logic              RLE_MODE,
  input  logic              TRIG_HIT,
  input  logic [ADDR_W-1:0] PRE_CNT,
  input  logic [ADDR_W-1:0] POST_CNT,
  input  logic              ADDR_CNT_EN,
  output logic              CAPTURE_CLK_EN,
  output logic              RLE_EN,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_WE_N,
  output logic [ADDR_W-1:0] TRIG_ADDR,
  output logic              TRIGGERED,
  output logic              WRAPPED,
  output logic              BUSY,
  output logic              DONE
);
  cap_state_e        state_q, state_d;
  logic              wr_gate_q, wr_gate_d;
  logic              cap_en_q, cap_en_d;
  logic              rle_en_q, rle_en_d;
  logic              triggered_q, triggered_d;
  logic              wrapped_q, wrapped_d;
  logic              done_q, done_d;
  logic              stop_pend_q, stop_pend_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
  logic [1:0]        flush_cnt_q, flush_cnt_d;

  logic              we, start_acc, go_flush, addr_wrap;
  logic [ADDR_W-1:0] addr;

  assign we        = ADDR_CNT_EN & wr_gate_q;
  assign start_acc = START & ((state_q == S_IDLE) || (state_q == S_DONE));

  la_wr_addr_cnt #(.ADDR_W(ADDR_W)) u_addr (
    .clk  (CLK),
    .rst  (RESET),
    .clr  (start_acc),
    .inc  (we),
    .addr (addr),
    .wrap (addr_wrap)
  );

  always_comb begin
    state_d     = state_q;
    wr_gate_d   = wr_gate_q;
    cap_en_d    = cap_en_q;
    rle_en_d    = rle_en_q;
    triggered_d = triggered_q;
    wrapped_d   = wrapped_q | addr_wrap;
    done_d      = done_q;
    stop_pend_d = stop_pend_q;
    trig_addr_d = trig_addr_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;
    flush_cnt_d = flush_cnt_q;
    go_flush    = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          state_d     = (PRE_CNT == '0) ? S_ARMED : S_PRE;
          wr_gate_d   = 1'b1;
          cap_en_d    = 1'b1;
          rle_en_d    = RLE_MODE;
          triggered_d = 1'b0;
          wrapped_d   = 1'b0;
          done_d      = 1'b0;
          stop_pend_d = 1'b0;
          trig_addr_d = '0;
          pre_cnt_d   = '0;
        end
      end
      S_PRE, S_ARMED, S_POST: begin
        // STOP is held one cycle before FLUSH; it also blocks any trigger
        // or phase change sampled on the same edge.
        if (stop_pend_q) begin
          go_flush = 1'b1;
        end else if (STOP) begin
          stop_pend_d = 1'b1;
        end else if (state_q == S_PRE) begin
          if (we) begin
            pre_cnt_d = pre_cnt_q + ADDR_W'(1);
            if (pre_cnt_d == PRE_CNT) state_d = S_ARMED;
          end
        end else if (state_q == S_ARMED) begin
          if (TRIG_HIT) begin
            trig_addr_d = addr;
            triggered_d = 1'b1;
            post_cnt_d  = POST_CNT;
            state_d     = S_POST;
          end
        end else begin
          if (post_cnt_q == '0) begin
            go_flush = 1'b1;
          end else if (we) begin
            post_cnt_d = post_cnt_q - ADDR_W'(1);
            if (post_cnt_d == '0) go_flush = 1'b1;
          end
        end
      end
      S_FLUSH: begin
        flush_cnt_d = flush_cnt_q + 2'd1;
        if (flush_cnt_q == 2'(FLUSH_LEN - 1)) begin
          state_d   = S_DONE;
          cap_en_d  = 1'b0;
          rle_en_d  = 1'b0;
          wr_gate_d = 1'b0;
          done_d    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Dropping RLE_EN drains the pending run through the RLE pipeline.
    if (go_flush) begin
      state_d     = S_FLUSH;
      flush_cnt_d = '0;
      rle_en_d    = 1'b0;
      stop_pend_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      wr_gate_q   <= 1'b0;
      cap_en_q    <= 1'b0;
      rle_en_q    <= 1'b0;
      triggered_q <= 1'b0;
      wrapped_q   <= 1'b0;
      done_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      trig_addr_q <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_gate_q   <= wr_gate_d;
      cap_en_q    <= cap_en_d;
      rle_en_q    <= rle_en_d;
      triggered_q <= triggered_d;
      wrapped_q   <= wrapped_d;
      done_q      <= done_d;
      stop_pend_q <= stop_pend_d;
      trig_addr_q <= trig_addr_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign CAPTURE_CLK_EN = cap_en_q;
  assign RLE_EN         = rle_en_q;
  assign SRAM_ADDR      = addr;
  assign SRAM_WE_N      = ~we;
  assign TRIG_ADDR      = trig_addr_q;
  assign TRIGGERED      = triggered_q;
  assign WRAPPED        = wrapped_q;
  // The write gate is open in exactly the busy states.
  assign BUSY           = wr_gate_q;
  assign DONE           = done_q;
endmodule

// File: tb/tb_la_capture_ctrl.sv
// Directed bench for la_capture_ctrl: full-width instance plus a 4-bit
// address instance for the ring-wrap case.
module tb_la_capture_ctrl;
  localparam int AW = 19;
  localparam int SW = 4;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          START = 1'b0, STOP = 1'b0, RLE_MODE = 1'b0;
  logic          TRIG_HIT = 1'b0, ADDR_CNT_EN = 1'b0;
  logic [AW-1:0] PRE_CNT = '0, POST_CNT = '0;
  logic          CAPTURE_CLK_EN, RLE_EN, SRAM_WE_N;
  logic [AW-1:0] SRAM_ADDR, TRIG_ADDR;
  logic          TRIGGERED, WRAPPED, BUSY, DONE;

  logic          s_start = 1'b0, s_trig = 1'b0, s_en = 1'b0;
  logic [SW-1:0] s_pre = '0, s_post = '0;
  logic          s_ce, s_rle, s_we_n, s_trg, s_wrap, s_busy, s_done;
  logic [SW-1:0] s_addr, s_taddr;

  int n_chk = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  la_capture_ctrl #(.ADDR_W(AW)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .STOP(STOP),
    .RLE_MODE(RLE_MODE), .TRIG_HIT(TRIG_HIT), .PRE_CNT(PRE_CNT),
    .POST_CNT(POST_CNT), .ADDR_CNT_EN(ADDR_CNT_EN),
    .CAPTURE_CLK_EN(CAPTURE_CLK_EN), .RLE_EN(RLE_EN),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_N(SRAM_WE_N), .TRIG_ADDR(TRIG_ADDR),
    .TRIGGERED(TRIGGERED), .WRAPPED(WRAPPED), .BUSY(BUSY), .DONE(DONE)
  );

  la_capture_ctrl #(.ADDR_W(SW)) dut_s (
    .CLK(CLK), .RESET(RESET), .START(s_start), .STOP(STOP),
    .RLE_MODE(RLE_MODE), .TRIG_HIT(s_trig), .PRE_CNT(s_pre),
    .POST_CNT(s_post), .ADDR_CNT_EN(s_en),
    .CAPTURE_CLK_EN(s_ce), .RLE_EN(s_rle),
    .SRAM_ADDR(s_addr), .SRAM_WE_N(s_we_n), .TRIG_ADDR(s_taddr),
    .TRIGGERED(s_trg), .WRAPPED(s_wrap), .BUSY(s_busy), .DONE(s_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, sample 1ns later, release inputs.
  task automatic step(input logic en, input logic trig, input logic st, input logic sp);
    ADDR_CNT_EN = en; TRIG_HIT = trig; START = st; STOP = sp;
    @(posedge CLK); #1;
    ADDR_CNT_EN = 1'b0; TRIG_HIT = 1'b0; START = 1'b0; STOP = 1'b0;
  endtask

  initial begin
    // reset values, write strobe held off even with a request present
    ADDR_CNT_EN = 1'b1;
    #2;
    chk("rst_we_n", 32'(SRAM_WE_N), 1);
    chk("rst_ce", 32'(CAPTURE_CLK_EN), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_addr", 32'(SRAM_ADDR), 0);
    chk("rst_done", 32'(DONE), 0);
    ADDR_CNT_EN = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(posedge CLK); #1;

    // 1: PRE=4 POST=3, trigger on 10th write
    PRE_CNT = 19'd4; POST_CNT = 19'd3;
    step(0, 0, 1, 0);
    chk("s1_ce", 32'(CAPTURE_CLK_EN), 1);
    chk("s1_busy", 32'(BUSY), 1);
    chk("s1_rle", 32'(RLE_EN), 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    ADDR_CNT_EN = 1'b1; #1;
    chk("s1_we_n", 32'(SRAM_WE_N), 0);
    for (int i = 0; i < 9; i++) step(1, 0, 0, 0);
    chk("s1_addr9", 32'(SRAM_ADDR), 9);
    chk("s1_notrig", 32'(TRIGGERED), 0);
    step(1, 1, 0, 0);
    chk("s1_taddr", 32'(TRIG_ADDR), 9);
    chk("s1_trig", 32'(TRIGGERED), 1);
    chk("s1_addr10", 32'(SRAM_ADDR), 10);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    chk("s1_flush_busy", 32'(BUSY), 1);
    chk("s1_flush_done", 32'(DONE), 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("s1_done_early", 32'(DONE), 0);
    step(1, 0, 0, 0);
    chk("s1_done", 32'(DONE), 1);
    chk("s1_addr16", 32'(SRAM_ADDR), 16);
    chk("s1_ce_off", 32'(CAPTURE_CLK_EN), 0);
    chk("s1_idle_busy", 32'(BUSY), 0);
    ADDR_CNT_EN = 1'b1; #1;
    chk("s1_we_n_off", 32'(SRAM_WE_N), 1);
    step(1, 0, 0, 0);
    chk("s1_addr_hold", 32'(SRAM_ADDR), 16);

    // 2: trigger held through PRE=5 is ignored until ARMED
    PRE_CNT = 19'd5; POST_CNT = 19'd2;
    step(0, 0, 1, 0);
    chk("s2_flags_clr", 32'({DONE, TRIGGERED}), 0);
    chk("s2_addr_clr", 32'(SRAM_ADDR), 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0);
    chk("s2_pre_notrig", 32'(TRIGGERED), 0);
    step(1, 1, 0, 0);
    chk("s2_taddr", 32'(TRIG_ADDR), 5);
    chk("s2_trig", 32'(TRIGGERED), 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    chk("s2_done", 32'(DONE), 1);
    chk("s2_addr", 32'(SRAM_ADDR), 11);

    // 3: 4-bit ring wraps with no trigger
    s_pre = 4'd2;
    s_start = 1'b1;
    @(posedge CLK); #1;
    s_start = 1'b0;
    s_en = 1'b1;
    for (int i = 0; i < 15; i++) begin @(posedge CLK); #1; end
    chk("s3_addr15", 32'(s_addr), 15);
    chk("s3_nowrap", 32'(s_wrap), 0);
    @(posedge CLK); #1;
    chk("s3_addr0", 32'(s_addr), 0);
    chk("s3_wrap", 32'(s_wrap), 1);
    for (int i = 0; i < 4; i++) begin @(posedge CLK); #1; end
    s_en = 1'b0;
    chk("s3_addr4", 32'(s_addr), 4);
    chk("s3_wrap_sticky", 32'(s_wrap), 1);
    chk("s3_busy", 32'(s_busy), 1);
    chk("s3_done", 32'(s_done), 0);

    // 5: START while busy ignored; STOP+TRIG in ARMED, STOP wins
    PRE_CNT = 19'd0; POST_CNT = 19'd4;
    step(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    chk("s5_start_ign", 32'(SRAM_ADDR), 4);
    chk("s5_busy", 32'(BUSY), 1);
    step(0, 1, 0, 1);
    chk("s5_stop_trig", 32'(TRIGGERED), 0);
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 0, 0);
      chk($sformatf("s5_done_s%0d", i), 32'(DONE), 0);
    end
    step(0, 0, 0, 0);
    chk("s5_done_s4", 32'(DONE), 1);
    chk("s5_trig_final", 32'(TRIGGERED), 0);
    step(0, 0, 0, 1);
    chk("s5_stop_in_done", 32'(DONE), 1);

    // 4: RLE mode, POST_CNT=0, flush drops RLE_EN and writes the run word
    RLE_MODE = 1'b1; PRE_CNT = 19'd1; POST_CNT = 19'd0;
    step(0, 0, 1, 0);
    chk("s4_rle_on", 32'(RLE_EN), 1);
    RLE_MODE = 1'b0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("s4_taddr", 32'(TRIG_ADDR), 1);
    chk("s4_rle_post", 32'(RLE_EN), 1);
    step(0, 0, 0, 0);
    chk("s4_rle_flush", 32'(RLE_EN), 0);
    chk("s4_busy", 32'(BUSY), 1);
    step(1, 0, 0, 0);
    chk("s4_flush_wr", 32'(SRAM_ADDR), 3);
    step(0, 0, 0, 0);
    chk("s4_done_early", 32'(DONE), 0);
    step(0, 0, 0, 0);
    chk("s4_done", 32'(DONE), 1);
    chk("s4_ce_off", 32'(CAPTURE_CLK_EN), 0);

    // 6: async reset mid-POST, then a clean capture
    PRE_CNT = 19'd0; POST_CNT = 19'd5;
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    ADDR_CNT_EN = 1'b1;
    #2 RESET = 1'b1;
    #1;
    chk("s6_we_n", 32'(SRAM_WE_N), 1);
    chk("s6_out", 32'({CAPTURE_CLK_EN, RLE_EN, TRIGGERED, WRAPPED, BUSY, DONE}), 0);
    chk("s6_addr", 32'(SRAM_ADDR), 0);
    chk("s6_taddr", 32'(TRIG_ADDR), 0);
    #1;
    RESET = 1'b0;
    ADDR_CNT_EN = 1'b0;
    @(posedge CLK); #1;
    PRE_CNT = 19'd2; POST_CNT = 19'd1;
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("s6r_taddr", 32'(TRIG_ADDR), 2);
    chk("s6r_trig", 32'(TRIGGERED), 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    chk("s6r_done", 32'(DONE), 1);
    chk("s6r_addr", 32'(SRAM_ADDR), 7);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
